// File: rtl/pll_lock_monitor_pkg.sv
// Shared PLL definitions: lock-monitor state encodings, default thresholds
// and small arithmetic helpers used by the lock monitor.
package pll_lock_monitor_pkg;

  localparam logic [1:0] HOLDOFF = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;
  localparam logic [1:0] JUMP    = 2'd3;

  localparam logic [15:0] DEF_HOLDOFF_SAMPLES = 16'd3000;
  localparam logic [15:0] DEF_LOCK_THRESH     = 16'd200;
  localparam logic [15:0] DEF_LOCK_SAMPLES    = 16'd1000;
  localparam logic [15:0] DEF_JUMP_THRESH     = 16'd100;

  // Offset-binary phase error sits here when the loop is perfectly locked.
  localparam logic [15:0] PHASE_CENTER = 16'h8000;

  typedef struct packed {
    logic [1:0]  state;
    logic [15:0] hold_cnt;
    logic [15:0] lock_cnt;
    logic [15:0] prev_pe;
    logic        error_jump;
    logic        locked;
    logic [7:0]  jump_count;
  } monitor_regs_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'd1;
  endfunction

endpackage

// File: rtl/pll_lock_monitor_abs_diff.sv
// Combinational |a - b| for 16-bit unsigned operands; the difference is formed
// in 17 bits so the magnitude always fits back into 16 bits.
module pll_abs_diff (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic [16:0] diff;
  logic [16:0] neg_diff;

  assign diff     = {1'b0, a} - {1'b0, b};
  assign neg_diff = {1'b0, b} - {1'b0, a};
  assign y        = diff[16] ? neg_diff[15:0] : diff[15:0];

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: qualifies phase-error samples, declares lock after a run of
// in-band samples, and fires a one-clk relock pulse on a phase jump or request.
module pll_lock_monitor
  import pll_lock_monitor_pkg::*;
#(
  parameter logic [15:0] HOLDOFF_SAMPLES = DEF_HOLDOFF_SAMPLES,
  parameter logic [15:0] LOCK_THRESH     = DEF_LOCK_THRESH,
  parameter logic [15:0] LOCK_SAMPLES    = DEF_LOCK_SAMPLES,
  parameter logic [15:0] JUMP_THRESH     = DEF_JUMP_THRESH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable_posedge,
  input  logic        pll_done,
  input  logic [15:0] phase_error,
  input  logic        manual_jump,
  output logic        error_jump,
  output logic        locked,
  output logic [1:0]  lock_state,
  output logic [7:0]  jump_count
);

  monitor_regs_t regs_reg;
  monitor_regs_t regs_next;

  logic        sample;
  logic        jump_trig;
  logic        go_jump;
  logic [15:0] dev;
  logic [15:0] delta;

  assign sample = enable_posedge & pll_done;

  pll_abs_diff u_dev (
    .a (phase_error),
    .b (PHASE_CENTER),
    .y (dev)
  );

  pll_abs_diff u_delta (
    .a (phase_error),
    .b (regs_reg.prev_pe),
    .y (delta)
  );

  assign jump_trig = (regs_reg.state == LOCKED) && sample && (delta > JUMP_THRESH);
  // A manual request and a threshold jump in the same cycle collapse into one JUMP.
  assign go_jump   = (regs_reg.state != JUMP) && (manual_jump || jump_trig);

  always_comb begin
    regs_next            = regs_reg;
    regs_next.error_jump = 1'b0;

    if (sample && (regs_reg.state != JUMP)) begin
      regs_next.prev_pe = phase_error;
    end

    case (regs_reg.state)
      HOLDOFF: begin
        if (sample) begin
          if (regs_reg.hold_cnt == HOLDOFF_SAMPLES - 16'd1) begin
            regs_next.state    = ACQUIRE;
            regs_next.hold_cnt = 16'd0;
            regs_next.lock_cnt = 16'd0;
          end else begin
            regs_next.hold_cnt = regs_reg.hold_cnt + 16'd1;
          end
        end
      end
      ACQUIRE: begin
        if (sample) begin
          if (dev <= LOCK_THRESH) begin
            if (regs_reg.lock_cnt == LOCK_SAMPLES - 16'd1) begin
              regs_next.state  = LOCKED;
              regs_next.locked = 1'b1;
            end else begin
              regs_next.lock_cnt = regs_reg.lock_cnt + 16'd1;
            end
          end else begin
            regs_next.lock_cnt = 16'd0;
          end
        end
      end
      LOCKED: begin
        regs_next.locked = 1'b1;
      end
      default: begin
        regs_next.state = HOLDOFF;
      end
    endcase

    // Entering JUMP registers the pulse and all its side effects on the same edge.
    if (go_jump) begin
      regs_next.state      = JUMP;
      regs_next.error_jump = 1'b1;
      regs_next.locked     = 1'b0;
      regs_next.hold_cnt   = 16'd0;
      regs_next.lock_cnt   = 16'd0;
      regs_next.jump_count = sat_inc8(regs_reg.jump_count);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_reg.state      <= HOLDOFF;
      regs_reg.hold_cnt   <= 16'd0;
      regs_reg.lock_cnt   <= 16'd0;
      regs_reg.prev_pe    <= PHASE_CENTER;
      regs_reg.error_jump <= 1'b0;
      regs_reg.locked     <= 1'b0;
      regs_reg.jump_count <= 8'd0;
    end else begin
      regs_reg <= regs_next;
    end
  end

  assign error_jump = regs_reg.error_jump;
  assign locked     = regs_reg.locked;
  assign lock_state = regs_reg.state;
  assign jump_count = regs_reg.jump_count;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: lock acquisition, jump detection,
// manual relock, counter saturation and reset during JUMP.
module tb_pll_lock_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable_posedge = 1'b0;
  logic        pll_done = 1'b0;
  logic [15:0] phase_error = 16'h8000;
  logic        manual_jump = 1'b0;
  logic        error_jump;
  logic        locked;
  logic [1:0]  lock_state;
  logic [7:0]  jump_count;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  bit consec = 1'b0;
  logic prev_ej = 1'b0;

  pll_lock_monitor dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable_posedge (enable_posedge),
    .pll_done       (pll_done),
    .phase_error    (phase_error),
    .manual_jump    (manual_jump),
    .error_jump     (error_jump),
    .locked         (locked),
    .lock_state     (lock_state),
    .jump_count     (jump_count)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (error_jump) pulse_cnt++;
    if (error_jump && prev_ej) consec = 1'b1;
    prev_ej = error_jump;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_sample(input logic [15:0] pe, input int gap);
    phase_error    = pe;
    enable_posedge = 1'b1;
    @(posedge clk);
    #1;
    enable_posedge = 1'b0;
    for (int i = 1; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show(input string what);
    $display("[%0t] %s: state=%0d locked=%0b ej=%0b jc=%0d pulses=%0d",
             $time, what, lock_state, locked, error_jump, jump_count, pulse_cnt);
  endtask

  initial begin
    int v;

    // Reset
    tick(3);
    chk("rst_state", lock_state, 2'd0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_ej", error_jump, 1'b0);
    chk("rst_jc", jump_count, 8'd0);
    show("reset");
    reset_n  = 1'b1;
    pll_done = 1'b1;
    tick(2);

    // Initial lock, a sample every 10 clks
    for (int i = 0; i < 2999; i++) do_sample(16'h8000, 10);
    chk("hold_2999", lock_state, 2'd0);
    do_sample(16'h8000, 10);
    chk("hold_3000", lock_state, 2'd1);
    for (int i = 0; i < 999; i++) do_sample(16'h8000, 10);
    chk("acq_999_state", lock_state, 2'd1);
    chk("acq_999_locked", locked, 1'b0);
    do_sample(16'h8000, 10);
    chk("lock1_state", lock_state, 2'd2);
    chk("lock1_locked", locked, 1'b1);
    chk("lock1_pulses", pulse_cnt, 0);
    show("first lock");

    // Step of exactly 100 each way: no jump
    do_sample(16'h8064, 2);
    chk("step100_locked", locked, 1'b1);
    do_sample(16'h8000, 2);
    chk("step100b_state", lock_state, 2'd2);
    show("step 100");

    // Strobe without pll_done is not a sample
    pll_done = 1'b0;
    do_sample(16'h9000, 2);
    chk("nodone_state", lock_state, 2'd2);
    pll_done = 1'b1;

    // Step of 101: one relock pulse
    do_sample(16'h8065, 1);
    chk("j1_ej", error_jump, 1'b1);
    chk("j1_state", lock_state, 2'd3);
    chk("j1_jc", jump_count, 8'd1);
    chk("j1_locked", locked, 1'b0);
    tick(1);
    chk("j1_ej_off", error_jump, 1'b0);
    chk("j1_holdoff", lock_state, 2'd0);
    chk("j1_pulses", pulse_cnt, 1);
    show("jump delta 101");

    // Relock with a dev=201 sample at lock_cnt=999; dev=200 still counts
    for (int i = 0; i < 2999; i++) do_sample(16'h8000, 2);
    chk("rh_2999", lock_state, 2'd0);
    do_sample(16'h8000, 2);
    chk("rh_3000", lock_state, 2'd1);
    for (int i = 0; i < 999; i++) do_sample(16'h7F38, 2);
    chk("dev200_state", lock_state, 2'd1);
    do_sample(16'h80C9, 2);
    chk("dev201_state", lock_state, 2'd1);
    chk("dev201_locked", locked, 1'b0);
    for (int i = 0; i < 999; i++) do_sample(16'h8000, 2);
    chk("delay_999_state", lock_state, 2'd1);
    chk("delay_999_locked", locked, 1'b0);
    do_sample(16'h8000, 2);
    chk("lock2_state", lock_state, 2'd2);
    chk("lock2_locked", locked, 1'b1);
    show("delayed lock");

    // Walk up to 16'hFFFF in steps of 100, then wrap to 0
    v = 32'h8000;
    while (v + 100 <= 32'hFFFF) begin
      v = v + 100;
      do_sample(v[15:0], 2);
    end
    do_sample(16'hFFFF, 2);
    chk("walk_state", lock_state, 2'd2);
    chk("walk_pulses", pulse_cnt, 1);
    do_sample(16'h0000, 1);
    chk("wrap_ej", error_jump, 1'b1);
    chk("wrap_jc", jump_count, 8'd2);
    tick(1);
    show("wrap jump");

    // Relock, then manual jump coinciding with a delta-101 sample
    for (int i = 0; i < 4000; i++) do_sample(16'h8000, 2);
    chk("lock3_locked", locked, 1'b1);
    manual_jump = 1'b1;
    do_sample(16'h8065, 1);
    chk("combo_ej", error_jump, 1'b1);
    chk("combo_jc", jump_count, 8'd3);
    tick(1);
    chk("man_in_jump_state", lock_state, 2'd0);
    chk("man_in_jump_ej", error_jump, 1'b0);
    chk("man_in_jump_jc", jump_count, 8'd3);
    manual_jump = 1'b0;
    tick(1);
    chk("combo_pulses", pulse_cnt, 3);
    show("manual + threshold");

    // Drive jump_count to saturation
    for (int i = 0; i < 252; i++) begin
      manual_jump = 1'b1;
      tick(1);
      manual_jump = 1'b0;
      tick(1);
    end
    chk("sat_jc", jump_count, 8'd255);
    chk("sat_pulses", pulse_cnt, 255);
    manual_jump = 1'b1;
    tick(1);
    manual_jump = 1'b0;
    chk("sat2_state", lock_state, 2'd3);
    chk("sat2_jc", jump_count, 8'd255);
    show("saturated");

    // Reset asserted while in JUMP
    reset_n = 1'b0;
    #1;
    chk("rj_state", lock_state, 2'd0);
    chk("rj_ej", error_jump, 1'b0);
    chk("rj_locked", locked, 1'b0);
    chk("rj_jc", jump_count, 8'd0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("post_rst_ej", error_jump, 1'b0);
    chk("post_rst_state", lock_state, 2'd0);
    chk("post_rst_pulses", pulse_cnt, 255);
    chk("no_consec", consec, 1'b0);
    show("reset in JUMP");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
